// File: rtl/physics_engine_multi.sv
// physics_engine_multi: multi-object gravity/velocity integrator with floor and
// wall collisions, driven by a frame tick and exposed as a memory-mapped
// register file.
//
// Ports:
//   clock      master clock, rising edge
//   reset      synchronous active-low reset
//   frame_tick single-cycle pulse that starts one sweep over all objects
//   wr_en      register write strobe
//   addr       register address (read and write)
//   wdata      write data
//   rdata      registered read data, one cycle after addr is sampled
//   busy       high while integrating/colliding
//   done       one-cycle pulse at sweep completion
//   grounded   per-object floor-contact flags
module physics_engine_multi #(
  parameter int unsigned N_OBJ  = 2,
  parameter int unsigned W      = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata,
  output logic              busy,
  output logic              done,
  output logic [N_OBJ-1:0]  grounded
);

  localparam int unsigned IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int unsigned B     = 4 * N_OBJ;

  localparam logic signed [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, INTEG, COLLIDE, DONE} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic signed [W-1:0] pos_x_q [N_OBJ];
  logic signed [W-1:0] pos_x_d [N_OBJ];
  logic signed [W-1:0] pos_y_q [N_OBJ];
  logic signed [W-1:0] pos_y_d [N_OBJ];
  logic signed [W-1:0] vel_x_q [N_OBJ];
  logic signed [W-1:0] vel_x_d [N_OBJ];
  logic signed [W-1:0] vel_y_q [N_OBJ];
  logic signed [W-1:0] vel_y_d [N_OBJ];

  logic signed [W-1:0] gravity_q, gravity_d;
  logic signed [W-1:0] floor_y_q, floor_y_d;
  logic signed [W-1:0] x_min_q, x_min_d;
  logic signed [W-1:0] x_max_q, x_max_d;
  logic [N_OBJ-1:0]    mask_q, mask_d;
  logic                overrun_q, overrun_d;
  logic [N_OBJ-1:0]    grounded_q, grounded_d;
  logic [W-1:0]        rdata_q, rdata_d;

  // Intermediates computed in INTEG, consumed in COLLIDE
  logic signed [W-1:0] vy_q, vy_d, px_q, px_d, py_q, py_d;
  logic signed [W-1:0] cur_px, cur_py, cur_vx, cur_vy;

  // Add at W+1 bits and clamp into the signed W-bit range
  function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) sat_add = s[W] ? S_MIN : S_MAX;
    else                sat_add = s[W-1:0];
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = INTEG;
          idx_d   = '0;
        end
      end
      INTEG:   state_d = COLLIDE;
      COLLIDE: begin
        if (idx_q == IDX_W'(N_OBJ - 1)) begin
          state_d = DONE;
        end else begin
          state_d = INTEG;
          idx_d   = IDX_W'(idx_q + 1'b1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, registered against the next state so they align with it
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_d == INTEG || state_d == COLLIDE) busy_d = 1'b1;
    if (state_d == DONE)                        done_d = 1'b1;
  end

  // Current-object mux
  always_comb begin
    cur_px = '0;
    cur_py = '0;
    cur_vx = '0;
    cur_vy = '0;
    for (int k = 0; k < N_OBJ; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_px = pos_x_q[k];
        cur_py = pos_y_q[k];
        cur_vx = vel_x_q[k];
        cur_vy = vel_y_q[k];
      end
    end
  end

  // Datapath: integrate, collide/write-back, then processor writes override
  always_comb begin
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    vel_x_d    = vel_x_q;
    vel_y_d    = vel_y_q;
    gravity_d  = gravity_q;
    floor_y_d  = floor_y_q;
    x_min_d    = x_min_q;
    x_max_d    = x_max_q;
    mask_d     = mask_q;
    overrun_d  = overrun_q;
    grounded_d = grounded_q;
    vy_d       = vy_q;
    px_d       = px_q;
    py_d       = py_q;

    if (state_q == INTEG) begin
      vy_d = sat_add(cur_vy, gravity_q);
      px_d = sat_add(cur_px, cur_vx);
      py_d = sat_add(cur_py, vy_d);
    end

    if (state_q == COLLIDE) begin
      for (int k = 0; k < N_OBJ; k++) begin
        if (idx_q == IDX_W'(k) && mask_q[k]) begin
          if (py_q >= floor_y_q) begin
            pos_y_d[k]    = floor_y_q;
            vel_y_d[k]    = '0;
            grounded_d[k] = 1'b1;
          end else begin
            pos_y_d[k]    = py_q;
            vel_y_d[k]    = vy_q;
            grounded_d[k] = 1'b0;
          end
          if (px_q < x_min_q) begin
            pos_x_d[k] = x_min_q;
            vel_x_d[k] = '0;
          end else if (px_q > x_max_q) begin
            pos_x_d[k] = x_max_q;
            vel_x_d[k] = '0;
          end else begin
            pos_x_d[k] = px_q;
          end
        end
      end
    end

    if (wr_en) begin
      for (int k = 0; k < N_OBJ; k++) begin
        if (addr == ADDR_W'(4 * k + 0)) pos_x_d[k] = wdata;
        if (addr == ADDR_W'(4 * k + 1)) pos_y_d[k] = wdata;
        if (addr == ADDR_W'(4 * k + 2)) vel_x_d[k] = wdata;
        if (addr == ADDR_W'(4 * k + 3)) vel_y_d[k] = wdata;
      end
      if (addr == ADDR_W'(B + 0)) gravity_d = wdata;
      if (addr == ADDR_W'(B + 1)) floor_y_d = wdata;
      if (addr == ADDR_W'(B + 2)) x_min_d   = wdata;
      if (addr == ADDR_W'(B + 3)) x_max_d   = wdata;
      if (addr == ADDR_W'(B + 4) && wdata[1]) overrun_d = 1'b0;
      if (addr == ADDR_W'(B + 5)) mask_d    = wdata[N_OBJ-1:0];
    end

    // A new overrun event takes precedence over a simultaneous clear
    if (frame_tick && state_q != IDLE) overrun_d = 1'b1;
  end

  // Read mux sees pre-write contents
  always_comb begin
    rdata_d = '0;
    for (int k = 0; k < N_OBJ; k++) begin
      if (addr == ADDR_W'(4 * k + 0)) rdata_d = pos_x_q[k];
      if (addr == ADDR_W'(4 * k + 1)) rdata_d = pos_y_q[k];
      if (addr == ADDR_W'(4 * k + 2)) rdata_d = vel_x_q[k];
      if (addr == ADDR_W'(4 * k + 3)) rdata_d = vel_y_q[k];
    end
    if (addr == ADDR_W'(B + 0)) rdata_d = gravity_q;
    if (addr == ADDR_W'(B + 1)) rdata_d = floor_y_q;
    if (addr == ADDR_W'(B + 2)) rdata_d = x_min_q;
    if (addr == ADDR_W'(B + 3)) rdata_d = x_max_q;
    if (addr == ADDR_W'(B + 4)) rdata_d = W'({grounded_q, overrun_q, busy_q});
    if (addr == ADDR_W'(B + 5)) rdata_d = W'(mask_q);
  end

  // Register file and output flops
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < N_OBJ; k++) begin
        pos_x_q[k] <= '0;
        pos_y_q[k] <= '0;
        vel_x_q[k] <= '0;
        vel_y_q[k] <= '0;
      end
      gravity_q  <= '0;
      floor_y_q  <= S_MAX;
      x_min_q    <= S_MIN;
      x_max_q    <= S_MAX;
      mask_q     <= '1;
      overrun_q  <= 1'b0;
      grounded_q <= '0;
      vy_q       <= '0;
      px_q       <= '0;
      py_q       <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      vel_x_q    <= vel_x_d;
      vel_y_q    <= vel_y_d;
      gravity_q  <= gravity_d;
      floor_y_q  <= floor_y_d;
      x_min_q    <= x_min_d;
      x_max_q    <= x_max_d;
      mask_q     <= mask_d;
      overrun_q  <= overrun_d;
      grounded_q <= grounded_d;
      vy_q       <= vy_d;
      px_q       <= px_d;
      py_q       <= py_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign grounded = grounded_q;

endmodule

// File: tb/tb_physics_engine_multi.sv
// Directed bench for physics_engine_multi: reads are queued with expected
// values and checked by an independent monitor when read data is presented.
module tb_physics_engine_multi;

  localparam int unsigned N  = 2;
  localparam int unsigned W  = 16;
  localparam int unsigned AW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          frame_tick = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  rdata;
  logic          busy;
  logic          done;
  logic [N-1:0]  grounded;

  int tests_run = 0;
  int failures  = 0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         rd_req  = 1'b0;
  logic         rd_pend = 1'b0;
  logic [W-1:0] mon_exp;
  string        mon_name;

  physics_engine_multi #(.N_OBJ(N), .W(W), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .wr_en(wr_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .grounded(grounded)
  );

  always #5 clock = ~clock;

  // Read data appears one edge after the request is sampled
  always @(posedge clock) rd_pend <= rd_req;

  // Monitor: pop and compare whenever a read response is presented
  always @(negedge clock) begin
    if (rd_pend) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read: got %0d with empty scoreboard", rdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (rdata !== mon_exp) begin
          failures++;
          $display("FAIL %s: got 0x%04h, expected 0x%04h", mon_name, rdata, mon_exp);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    wr_en = 1'b1;
    addr  = AW'(a);
    wdata = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input int a, input logic [W-1:0] exp, input string nm);
    addr = AW'(a);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  // Issue a tick and count cycles until done (expected 2*N+1)
  task automatic tick_lat(input string nm);
    int n;
    bit seen;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check({nm, "_busy"}, W'(busy), W'(1));
    n = 1;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clock);
      if (done) seen = 1'b1;
      else      n++;
    end
    tests_run++;
    if (!seen || n != 2 * N + 1) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles (seen=%0d), expected %0d", nm, n, seen, 2 * N + 1);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    bit  seen;

    // Reset defaults
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_grounded", W'(grounded), W'(0));
    rd(11, 16'd32767, "rst_x_max");
    rd(12, 16'd0,     "rst_status");
    rd(13, 16'd3,     "rst_mask");
    rd(1,  16'd0,     "rst_pos_y0");
    rd(10, 16'h8000,  "rst_x_min");
    rd(9,  16'd32767, "rst_floor");
    wr(20, 16'h1234);
    rd(20, 16'd0,     "unmapped_rd");

    // Gravity
    wr(8, 16'd2);
    wr(1, 16'd100);
    wr(3, 16'd0);
    tick_lat("grav1");
    rd(3, 16'd2,   "grav1_vy0");
    rd(1, 16'd102, "grav1_py0");
    tick_lat("grav2");
    rd(3, 16'd4,   "grav2_vy0");
    rd(1, 16'd106, "grav2_py0");
    rd(7, 16'd4,   "grav2_vy1");
    rd(5, 16'd6,   "grav2_py1");

    // Floor
    wr(9, 16'd110);
    wr(8, 16'd1);
    wr(1, 16'd108);
    wr(3, 16'd5);
    tick_lat("floor1");
    rd(1, 16'd110, "floor1_py0");
    rd(3, 16'd0,   "floor1_vy0");
    rd(12, 16'd4,  "floor1_status");
    check("floor1_grounded", W'(grounded), W'(2'b01));
    wr(1, 16'd50);
    tick_lat("floor2");
    check("floor2_grounded", W'(grounded), W'(2'b00));
    rd(1, 16'd51,  "floor2_py0");
    // Landing exactly on the floor counts as contact
    wr(1, 16'd109);
    wr(3, 16'd0);
    tick_lat("floor3");
    rd(1, 16'd110, "floor3_py0");
    check("floor3_grounded", W'(grounded), W'(2'b01));
    wr(9, 16'd32767);
    wr(8, 16'd0);

    // Walls
    wr(10, 16'd0);
    wr(11, 16'd639);
    wr(0, 16'd635);
    wr(2, 16'd10);
    wr(4, 16'd3);
    wr(6, 16'hFFFB);
    tick_lat("wall1");
    rd(0, 16'd639, "wall1_px0");
    rd(2, 16'd0,   "wall1_vx0");
    rd(4, 16'd0,   "wall1_px1");
    rd(6, 16'd0,   "wall1_vx1");
    wr(4, 16'd5);
    wr(6, 16'hFFFB);
    tick_lat("wall2");
    rd(4, 16'd0,   "wall2_px1_edge");
    rd(6, 16'hFFFB, "wall2_vx1_kept");
    rd(0, 16'd639, "wall2_px0_edge");

    // Saturation
    wr(11, 16'd32767);
    wr(0, 16'd32760);
    wr(2, 16'd100);
    tick_lat("sat");
    rd(0, 16'd32767, "sat_px0");
    rd(2, 16'd100,   "sat_vx0");

    // Disabled object
    wr(13, 16'd1);
    wr(4, 16'd20);
    wr(6, 16'd7);
    wr(5, 16'd30);
    wr(7, 16'd3);
    tick_lat("dis");
    rd(4, 16'd20,  "dis_px1");
    rd(6, 16'd7,   "dis_vx1");
    rd(5, 16'd30,  "dis_py1");
    rd(7, 16'd3,   "dis_vy1");
    rd(2, 16'd100, "dis_vx0");

    // Overrun
    frame_tick = 1'b1;
    step();
    step();
    frame_tick = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clock);
      if (done) seen = 1'b1;
      n++;
    end
    check("ovr_done_seen", W'(seen), W'(1));
    step();
    rd(12, 16'd2, "ovr_status_set");
    wr(12, 16'd2);
    rd(12, 16'd0, "ovr_status_clr");

    // Mid-sweep reset during COLLIDE of object 0
    wr(13, 16'd3);
    wr(1, 16'd77);
    wr(8, 16'd5);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mrst_busy", W'(busy), W'(0));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    check("mrst_no_done", W'(seen), W'(0));
    step();
    rd(1,  16'd0,     "mrst_py0");
    rd(3,  16'd0,     "mrst_vy0");
    rd(8,  16'd0,     "mrst_gravity");
    rd(11, 16'd32767, "mrst_x_max");
    rd(13, 16'd3,     "mrst_mask");
    rd(12, 16'd0,     "mrst_status");

    repeat (3) step();
    check("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
